exe_mem_issue_stage: RTL and testbench
======================================

// Module: exe_mem_issue_stage
// PURPOSE
//  EXE pipeline stage: latches decoded ops from ID, computes the ALU result and issues
//  load/store requests on the data SRAM-like bus (req/addr_ok). It feeds the MEM stage,
//  which waits for data_ok when exe_mem_req=1. It also detects ALE, aligns store data and
//  drives forwarding/load-use info. Bus-req suppression applies only to requests not yet accepted.
// PARAMETERS
//  none (fixed 32-bit datapath, 5-bit register index)
// PORTS
//  clk               in   1   clock
//  reset             in   1   synchronous, active-high
//  id_to_exe_valid   in   1   ID holds a valid instruction
//  id_alu_op         in   4   0 add,1 sub,2 slt,3 sltu,4 and,5 or,6 nor,7 xor,8 sll,9 srl,10 sra,11 lui(=src2); 12-15 -> 0
//  id_src1/id_src2   in   32  ALU operands (shift amount = src2[4:0])
//  id_pc             in   32  instruction PC
//  id_dest/id_gr_we  in   5/1 destination register / GPR write enable
//  id_mem_re/id_mem_we in 1/1 load / store
//  id_mem_size       in   2   0 byte,1 half,2 word (3 treated as word)
//  id_st_data        in   32  store source register value
//  id_exc            in   1   exception already flagged upstream
//  exe_allow         out  1   EXE can accept from ID
//  mem_allow         in   1   MEM can accept from EXE
//  mem_exception     in   1   MEM holds an exception-causing instr: no new bus request
//  wb_exception      in   1   flush: kill EXE contents
//  exe_to_mem_valid  out  1   valid hand-off to MEM
//  exe_alu_result, exe_pc out 32 each; exe_dest 5; exe_gr_we, exe_res_from_mem 1
//  exe_mem_req       out  1   request of this instr was accepted (MEM must wait data_ok)
//  exe_except_ale    out  1   misaligned access
//  exe_exc           out  1   id_exc | ale, registered-instr view
//  exe_dest_bus      out  5   exe_valid&gr_we ? dest : 0
//  exe_value_bus     out  32  ALU result for forwarding
//  exe_load_pending  out  1   exe_valid & mem_re (ID load-use stall)
//  data_sram_req/wr  out  1/1 request / write
//  data_sram_size    out  2   = registered mem_size
//  data_sram_wstrb   out  4   byte strobes (0 for loads)
//  data_sram_addr/wdata out 32 address (=alu add result) / replicated store data
//  data_sram_addr_ok in   1   request accepted this cycle
// BEHAVIOUR
//  - Reset: exe_valid=0, req_done=0, instr regs 0 -> all valid/req/bus/dest outputs 0.
//  - wb_exception (priority over all): exe_valid<=0, req_done<=0; data_sram_req=0 same cycle.
//  - Else if exe_allow: exe_valid<=id_to_exe_valid; regs load when id_to_exe_valid&exe_allow.
//  - acc = exe_valid&(mem_re|mem_we); skip = exe_exc (no bus access).
//  - data_sram_req = acc&~skip&~req_done&~mem_exception&~wb_exception; comb, may drop before
//    addr_ok (only the req&addr_ok cycle is a handshake).
//  - req_done <= 1 on req&addr_ok when not (exe_to_mem_valid&mem_allow); cleared on hand-off/flush.
//  - exe_go = ~acc | skip | req_done | (req&addr_ok). exe_allow = ~exe_valid | exe_go&mem_allow.
//  - exe_to_mem_valid = exe_valid&exe_go. exe_mem_req = acc&~skip.
//  - mem_exception with request not accepted: stall (go=0) until flush.
//  - Latency: non-memory instr 1 cycle; memory instr 1 cycle + addr_ok wait.
//  - ALE: half & addr[0]; word & addr[1:0]!=0; byte never.
//  - wstrb: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111; load 0000.
//  - wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - ALU: 32-bit wraparound add/sub; slt signed, sltu unsigned -> 0/1; sra arithmetic.
//  - exe_res_from_mem = mem_re. Accepted-then-flushed request: MEM drops its data_ok.
// TESTING
//  - add 0x7FFFFFFF+1, mem_allow=1 -> exe_alu_result 0x80000000 next cycle, no req.
//  - st.b d=0x12345678, addr 0x1003, addr_ok after 3 cycles -> req held 3 cycles, wstrb 1000,
//    wdata 0x78787878, exe_to_mem_valid on accept cycle, exe_mem_req=1.
//  - ld.w addr 0x1002 -> ale=1, req never asserted, passes to MEM next cycle.
//  - ld.h accepted while mem_allow=0 -> req_done=1, req drops, no second request when mem_allow rises.
//  - mem_exception=1 with pending load -> req=0, stall; wb_exception -> exe_valid=0 next cycle.
//  - reset asserted mid-wait -> req=0, exe_to_mem_valid=0, exe_dest_bus=0 after reset edge.

Source files
------------

// File: rtl/exe_mem_issue_stage.sv
// exe_mem_issue_stage: EXE stage - ALU, data-bus request issue, ALE, store alignment, forwarding.
module exe_mem_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_to_exe_valid,
  input  logic [3:0]  id_alu_op,
  input  logic [31:0] id_src1,
  input  logic [31:0] id_src2,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_dest,
  input  logic        id_gr_we,
  input  logic        id_mem_re,
  input  logic        id_mem_we,
  input  logic [1:0]  id_mem_size,
  input  logic [31:0] id_st_data,
  input  logic        id_exc,
  output logic        exe_allow,
  input  logic        mem_allow,
  input  logic        mem_exception,
  input  logic        wb_exception,
  output logic        exe_to_mem_valid,
  output logic [31:0] exe_alu_result,
  output logic [31:0] exe_pc,
  output logic [4:0]  exe_dest,
  output logic        exe_gr_we,
  output logic        exe_res_from_mem,
  output logic        exe_mem_req,
  output logic        exe_except_ale,
  output logic        exe_exc,
  output logic [4:0]  exe_dest_bus,
  output logic [31:0] exe_value_bus,
  output logic        exe_load_pending,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok
);
  logic        exe_valid_q, exe_valid_d, req_done_q, req_done_d;
  logic [3:0]  alu_op_q;
  logic [31:0] src1_q, src2_q, pc_q, st_data_q;
  logic [4:0]  dest_q;
  logic        gr_we_q, mem_re_q, mem_we_q, exc_q;
  logic [1:0]  mem_size_q;
  logic        acc, go, hs, load;
  logic [31:0] sum, res;
  assign sum = src1_q + src2_q;
  always_comb begin
    res = '0;
    case (alu_op_q)
      4'd0:  res = sum;
      4'd1:  res = src1_q - src2_q;
      4'd2:  res = {31'b0, $signed(src1_q) < $signed(src2_q)};
      4'd3:  res = {31'b0, src1_q < src2_q};
      4'd4:  res = src1_q & src2_q;
      4'd5:  res = src1_q | src2_q;
      4'd6:  res = ~(src1_q | src2_q);
      4'd7:  res = src1_q ^ src2_q;
      4'd8:  res = src1_q << src2_q[4:0];
      4'd9:  res = src1_q >> src2_q[4:0];
      4'd10: res = $unsigned($signed(src1_q) >>> src2_q[4:0]);
      4'd11: res = src2_q;
      default: res = '0;
    endcase
  end
  assign exe_except_ale = (mem_re_q | mem_we_q) &
                          (mem_size_q == 2'd1 ? sum[0] : mem_size_q[1] ? |sum[1:0] : 1'b0);
  assign exe_exc          = exc_q | exe_except_ale;
  assign acc              = exe_valid_q & (mem_re_q | mem_we_q);
  assign data_sram_req    = acc & ~exe_exc & ~req_done_q & ~mem_exception & ~wb_exception;
  assign hs               = data_sram_req & data_sram_addr_ok;
  assign go               = ~acc | exe_exc | req_done_q | hs;
  assign exe_allow        = ~exe_valid_q | (go & mem_allow);
  assign exe_to_mem_valid = exe_valid_q & go;
  assign exe_mem_req      = acc & ~exe_exc;
  assign load             = id_to_exe_valid & exe_allow & ~wb_exception;
  assign exe_valid_d      = wb_exception ? 1'b0 : exe_allow ? id_to_exe_valid : exe_valid_q;
  // A request accepted in its hand-off cycle never needs remembering.
  assign req_done_d       = wb_exception ? 1'b0 : (exe_to_mem_valid & mem_allow) ? 1'b0 :
                            hs ? 1'b1 : req_done_q;
  assign exe_alu_result   = res;
  assign exe_value_bus    = res;
  assign exe_pc           = pc_q;
  assign exe_dest         = dest_q;
  assign exe_gr_we        = gr_we_q;
  assign exe_res_from_mem = mem_re_q;
  assign exe_dest_bus     = (exe_valid_q & gr_we_q) ? dest_q : 5'd0;
  assign exe_load_pending = exe_valid_q & mem_re_q;
  assign data_sram_wr     = mem_we_q;
  assign data_sram_size   = mem_size_q;
  assign data_sram_addr   = sum;
  assign data_sram_wstrb  = ~mem_we_q ? 4'b0000 :
                            mem_size_q == 2'd0 ? 4'b0001 << sum[1:0] :
                            mem_size_q == 2'd1 ? 4'b0011 << {sum[1], 1'b0} : 4'b1111;
  assign data_sram_wdata  = mem_size_q == 2'd0 ? {4{st_data_q[7:0]}} :
                            mem_size_q == 2'd1 ? {2{st_data_q[15:0]}} : st_data_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid_q <= 1'b0;
      req_done_q  <= 1'b0;
      alu_op_q    <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      pc_q        <= '0;
      dest_q      <= '0;
      gr_we_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      st_data_q   <= '0;
      exc_q       <= 1'b0;
    end else begin
      exe_valid_q <= exe_valid_d;
      req_done_q  <= req_done_d;
      if (load) begin
        alu_op_q   <= id_alu_op;
        src1_q     <= id_src1;
        src2_q     <= id_src2;
        pc_q       <= id_pc;
        dest_q     <= id_dest;
        gr_we_q    <= id_gr_we;
        mem_re_q   <= id_mem_re;
        mem_we_q   <= id_mem_we;
        mem_size_q <= id_mem_size;
        st_data_q  <= id_st_data;
        exc_q      <= id_exc;
      end
    end
  end
endmodule

// File: tb/tb_exe_mem_issue_stage.sv
// tb_exe_mem_issue_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_exe_mem_issue_stage;
  logic clk = 0, reset = 1;
  logic id_to_exe_valid = 0, id_gr_we = 0, id_mem_re = 0, id_mem_we = 0, id_exc = 0;
  logic [3:0] id_alu_op = 0;
  logic [31:0] id_src1 = 0, id_src2 = 0, id_pc = 0, id_st_data = 0;
  logic [4:0] id_dest = 0;
  logic [1:0] id_mem_size = 0;
  logic mem_allow = 1, mem_exception = 0, wb_exception = 0, data_sram_addr_ok = 0;
  logic exe_allow, exe_to_mem_valid, exe_gr_we, exe_res_from_mem, exe_mem_req, exe_except_ale;
  logic exe_exc, exe_load_pending, data_sram_req, data_sram_wr;
  logic [31:0] exe_alu_result, exe_pc, exe_value_bus, data_sram_addr, data_sram_wdata;
  logic [4:0] exe_dest, exe_dest_bus;
  logic [1:0] data_sram_size;
  logic [3:0] data_sram_wstrb;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  exe_mem_issue_stage dut (
    .clk(clk), .reset(reset), .id_to_exe_valid(id_to_exe_valid), .id_alu_op(id_alu_op),
    .id_src1(id_src1), .id_src2(id_src2), .id_pc(id_pc), .id_dest(id_dest), .id_gr_we(id_gr_we),
    .id_mem_re(id_mem_re), .id_mem_we(id_mem_we), .id_mem_size(id_mem_size),
    .id_st_data(id_st_data), .id_exc(id_exc), .exe_allow(exe_allow), .mem_allow(mem_allow),
    .mem_exception(mem_exception), .wb_exception(wb_exception),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_alu_result(exe_alu_result), .exe_pc(exe_pc),
    .exe_dest(exe_dest), .exe_gr_we(exe_gr_we), .exe_res_from_mem(exe_res_from_mem),
    .exe_mem_req(exe_mem_req), .exe_except_ale(exe_except_ale), .exe_exc(exe_exc),
    .exe_dest_bus(exe_dest_bus), .exe_value_bus(exe_value_bus),
    .exe_load_pending(exe_load_pending), .data_sram_req(data_sram_req),
    .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok));
  typedef struct packed {
    logic [3:0] op; logic [31:0] s1, s2, pc, st; logic [4:0] dest;
    logic gwe, re, wm, exc; logic [1:0] size;
  } ins_t;
  ins_t m_slot = '0;
  logic m_valid = 0, m_done = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a + ~b + 32'd1;
      4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: return (a < b) ? 32'd1 : 32'd0;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return ~(a | b);
      4'd7: return a ^ b;
      4'd8: return a << sh;
      4'd9: return a >> sh;
      4'd10: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction
  // Compare every output against the model at the negedge, then advance the model.
  task automatic step();
    ins_t s;
    logic [31:0] addr, wd;
    logic [3:0] ws;
    int nb, base;
    logic ale, exc, mem, req, hs, go, tomem, allow;
    @(negedge clk);
    s = m_slot;
    addr = s.s1 + s.s2;
    nb = s.size == 2'd0 ? 1 : s.size == 2'd1 ? 2 : 4;
    ale = (s.re || s.wm) && (addr % nb != 0);
    exc = s.exc || ale;
    mem = m_valid && (s.re || s.wm);
    req = mem && !exc && !m_done && !mem_exception && !wb_exception;
    hs = req && data_sram_addr_ok;
    go = !mem || exc || m_done || hs;
    tomem = m_valid && go;
    allow = !m_valid || (go && mem_allow);
    base = int'(addr % 4) / nb * nb;
    for (int i = 0; i < 4; i++) begin
      ws[i] = s.wm && i >= base && i < base + nb;
      wd[8*i +: 8] = s.st[8*(i % nb) +: 8];
    end
    chk("allow", exe_allow, allow);
    chk("to_mem", exe_to_mem_valid, tomem);
    chk("alu", exe_alu_result, alu(s.op, s.s1, s.s2));
    chk("value_bus", exe_value_bus, alu(s.op, s.s1, s.s2));
    chk("pc", exe_pc, s.pc);
    chk("dest", exe_dest, s.dest);
    chk("gr_we", exe_gr_we, s.gwe);
    chk("res_from_mem", exe_res_from_mem, s.re);
    chk("mem_req", exe_mem_req, mem && !exc);
    chk("ale", exe_except_ale, ale);
    chk("exc", exe_exc, exc);
    chk("dest_bus", exe_dest_bus, (m_valid && s.gwe) ? s.dest : 5'd0);
    chk("load_pend", exe_load_pending, m_valid && s.re);
    chk("req", data_sram_req, req);
    chk("wr", data_sram_wr, s.wm);
    chk("size", data_sram_size, s.size);
    chk("wstrb", data_sram_wstrb, ws);
    chk("addr", data_sram_addr, addr);
    chk("wdata", data_sram_wdata, wd);
    if (reset) begin
      m_valid = 0; m_done = 0; m_slot = '0;
    end else if (wb_exception) begin
      m_valid = 0; m_done = 0;
    end else begin
      if (tomem && mem_allow) m_done = 0;
      else if (hs) m_done = 1;
      if (allow) begin
        m_valid = id_to_exe_valid;
        if (id_to_exe_valid)
          m_slot = '{op: id_alu_op, s1: id_src1, s2: id_src2, pc: id_pc, st: id_st_data,
                     dest: id_dest, gwe: id_gr_we, re: id_mem_re, wm: id_mem_we,
                     exc: id_exc, size: id_mem_size};
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic re, input logic we, input logic [1:0] sz, input logic [31:0] d,
                        input logic [4:0] dst, input logic gwe);
    id_to_exe_valid = v; id_alu_op = op; id_src1 = a; id_src2 = b; id_mem_re = re;
    id_mem_we = we; id_mem_size = sz; id_st_data = d; id_dest = dst; id_gr_we = gwe;
    id_exc = 0; id_pc = id_pc + 32'd4;
  endtask
  initial begin
    step(); step();
    reset = 0;
    set_id(1, 4'd0, 32'h7FFFFFFF, 32'd1, 0, 0, 2'd0, 0, 5'd3, 1);
    step();
    id_to_exe_valid = 0;
    chk("add_ovf", exe_alu_result, 32'h80000000);
    chk("add_noreq", data_sram_req, 1'b0);
    chk("add_dest_bus", exe_dest_bus, 5'd3);
    step();
    set_id(1, 4'd0, 32'h1000, 32'd3, 0, 1, 2'd0, 32'h12345678, 5'd0, 0);
    step();
    id_to_exe_valid = 0;
    chk("stb_req", data_sram_req, 1'b1);
    chk("stb_wstrb", data_sram_wstrb, 4'b1000);
    chk("stb_wdata", data_sram_wdata, 32'h78787878);
    chk("stb_wait", exe_to_mem_valid, 1'b0);
    step(); step();
    data_sram_addr_ok = 1;
    #1;
    chk("stb_accept", exe_to_mem_valid, 1'b1);
    chk("stb_memreq", exe_mem_req, 1'b1);
    step();
    data_sram_addr_ok = 0;
    set_id(1, 4'd0, 32'h1000, 32'd2, 1, 0, 2'd2, 0, 5'd4, 1);
    step();
    id_to_exe_valid = 0;
    chk("ldw_ale", exe_except_ale, 1'b1);
    chk("ldw_noreq", data_sram_req, 1'b0);
    chk("ldw_pass", exe_to_mem_valid, 1'b1);
    step();
    set_id(1, 4'd0, 32'h1000, 32'd0, 1, 0, 2'd1, 0, 5'd6, 1);
    mem_allow = 0; data_sram_addr_ok = 1;
    step();
    id_to_exe_valid = 0;
    step();
    chk("ldh_done_noreq", data_sram_req, 1'b0);
    chk("ldh_valid", exe_to_mem_valid, 1'b1);
    step();
    mem_allow = 1;
    #1;
    chk("ldh_no_second", data_sram_req, 1'b0);
    step();
    data_sram_addr_ok = 0;
    set_id(1, 4'd0, 32'h1000, 32'd4, 1, 0, 2'd2, 0, 5'd7, 1);
    mem_exception = 1;
    step();
    id_to_exe_valid = 0;
    chk("mexc_noreq", data_sram_req, 1'b0);
    chk("mexc_stall", exe_to_mem_valid, 1'b0);
    step();
    wb_exception = 1;
    step();
    wb_exception = 0; mem_exception = 0;
    chk("flush_valid", exe_load_pending, 1'b0);
    chk("flush_tomem", exe_to_mem_valid, 1'b0);
    set_id(1, 4'd0, 32'h2000, 32'd0, 1, 0, 2'd2, 0, 5'd5, 1);
    step();
    id_to_exe_valid = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("rst_req", data_sram_req, 1'b0);
    chk("rst_tomem", exe_to_mem_valid, 1'b0);
    chk("rst_dest_bus", exe_dest_bus, 5'd0);
    for (int n = 0; n < 1500; n++) begin
      int kind = $urandom_range(0, 3);
      set_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
             kind < 2 ? 32'h1000 + $urandom_range(0, 15) : $urandom, $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)),
             kind == 0, kind == 1, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      id_exc = $urandom_range(0, 15) == 0;
      mem_allow = $urandom_range(0, 3) != 0;
      data_sram_addr_ok = $urandom_range(0, 2) == 0;
      mem_exception = $urandom_range(0, 31) == 0;
      wb_exception = $urandom_range(0, 39) == 0;
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
